// File: rtl/bk_add_sched.sv
// Two-requester scheduler that adds wide operands one 16-bit word per cycle
// through a single shared Brent-Kung adder, with round-robin arbitration.

module brent_kung (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [15:0] carry_pfx;
  logic [15:0] carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : gen_gp
      assign gen[gi]  = a[gi] & b[gi];
      assign prop[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Carry-in folds into bit 0 so every prefix node yields the true carry out of its bit.
  always_comb begin : prefix_tree
    logic [15:0] g;
    logic [15:0] p;
    g    = gen;
    p    = prop;
    g[0] = gen[0] | (prop[0] & cin);
    for (int d = 1; d < 16; d = d * 2) begin
      for (int i = 2 * d - 1; i < 16; i += 2 * d) begin
        g[i] = g[i] | (p[i] & g[i - d]);
        p[i] = p[i] & p[i - d];
      end
    end
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < 16; i += 2 * d) begin
        g[i] = g[i] | (p[i] & g[i - d]);
        p[i] = p[i] & p[i - d];
      end
    end
    carry_pfx = g;
  end

  assign carry_in = {carry_pfx[14:0], cin};
  assign sum      = prop ^ carry_in;
  assign cout     = carry_pfx[15];

endmodule

module bk_add_sched #(
  parameter int NWORDS = 4,
  localparam int W     = 16 * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST = 3'(NWORDS - 1);

  state_t       state_reg;
  state_t       state_next;
  logic [2:0]   cnt_reg;
  logic         carry_reg;
  logic         lp_reg;
  logic         cin_reg;
  logic         id_reg;
  logic         cout_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] sum_reg;

  logic         any_valid;
  logic         gnt_id;
  logic         accept;
  logic         last_word;
  logic [6:0]   word_idx;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_cin;
  logic [15:0]  add_sum;
  logic         add_cout;

  // On a tie the requester that was not granted last wins.
  assign any_valid = req0_valid | req1_valid;
  assign gnt_id    = (req0_valid & req1_valid) ? ~lp_reg : req1_valid;
  assign accept    = (state_reg == IDLE) & any_valid & ~rst;
  assign last_word = (cnt_reg == LAST);
  assign word_idx  = {cnt_reg, 4'b0000};

  assign add_a   = a_reg[word_idx +: 16];
  assign add_b   = b_reg[word_idx +: 16];
  assign add_cin = (cnt_reg == 3'd0) ? cin_reg : carry_reg;

  brent_kung u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~gnt_id;
    req1_ready = accept & gnt_id;
    rsp_valid  = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= 3'd0;
      carry_reg <= 1'b0;
      lp_reg    <= 1'b1;
      cin_reg   <= 1'b0;
      id_reg    <= 1'b0;
      cout_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg   <= gnt_id ? req1_a : req0_a;
            b_reg   <= gnt_id ? req1_b : req0_b;
            cin_reg <= gnt_id ? req1_cin : req0_cin;
            id_reg  <= gnt_id;
            lp_reg  <= gnt_id;
            cnt_reg <= 3'd0;
          end
        end
        RUN: begin
          sum_reg[word_idx +: 16] <= add_sum;
          carry_reg               <= add_cout;
          if (last_word) begin
            cout_reg <= add_cout;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_sum  = sum_reg;
  assign rsp_cout = cout_reg;
  assign rsp_id   = id_reg;

endmodule
